// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : execute stage of the 5-stage MIPS pipeline.
//
// Holds the integer ALU, an iterative 32-step multiply/divide unit with its
// HI/LO registers, destination-register selection and the EX/MEM register.
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        synchronous, active-high
//   ctrlEX       {RegDst, ALUSrc, ALUOp[1:0]}
//   ctrlMEMWB    MEM/WB control, forwarded to controlBits
//   read1/read2  rs / rt register operands
//   immediate    sign-extended immediate ([5:0] funct, [10:6] shamt)
//   rt/rd        candidate destination registers
//   controlBits  registered ctrlMEMWB
//   resultULA    registered ALU / HI / LO result
//   read2Out     registered read2 (store data)
//   entradaMUX5  registered destination register
//   stall        combinational; freezes PC, IF/ID and ID/EX
// ---------------------------------------------------------------------------
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrlEX,
  input  logic [4:0]  ctrlMEMWB,
  input  logic [31:0] read1,
  input  logic [31:0] read2,
  input  logic [31:0] immediate,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic [4:0]  controlBits,
  output logic [31:0] resultULA,
  output logic [31:0] read2Out,
  output logic [4:0]  entradaMUX5,
  output logic        stall
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Two's-complement magnitude; unsigned operands pass through untouched.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Decoded instruction fields
  logic        reg_dst;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        is_md;
  logic        is_mfhilo;
  logic        md_issue;

  // Multiply/divide state
  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;          // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opb_q, opb_d;          // multiplicand / divisor magnitude
  logic [31:0] dividend_q, dividend_d;
  logic [1:0]  md_op_q, md_op_d;      // funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath intermediates
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] step_acc;
  logic [63:0] product;
  logic [31:0] fin_hi;
  logic [31:0] fin_lo;
  logic [31:0] alu_result;

  // EX/MEM register
  logic [4:0]  ctrl_q, ctrl_d;
  logic [31:0] result_q, result_d;
  logic [31:0] read2_q, read2_d;
  logic [4:0]  dest_q, dest_d;

  // Field decode and operand selection
  always_comb begin
    reg_dst   = ctrlEX[3];
    alu_src   = ctrlEX[2];
    alu_op    = ctrlEX[1:0];
    funct     = immediate[5:0];
    shamt     = immediate[10:6];
    op_a      = read1;
    op_b      = alu_src ? immediate : read2;
    // 0x18..0x1B all share funct[5:2] = 4'b0110
    is_md     = (alu_op == 2'b10) && (funct[5:2] == 4'b0110);
    is_mfhilo = (alu_op == 2'b10) && ((funct == 6'h10) || (funct == 6'h12));
    // Issue is only recognised in IDLE so the md held in ID/EX during DONE does not restart
    md_issue  = (state_q == MD_IDLE) && is_md;
    stall     = md_issue || (state_q == MD_BUSY) || (is_mfhilo && (state_q == MD_BUSY));
  end

  // One shift-add / restoring-subtract step plus the final sign fix-ups
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Remainder after the shift is < 2*divisor, so bit 32 of the trial is the borrow
    div_trial = acc_q[63:31] - {1'b0, opb_q};
    if (md_op_q[1]) begin
      if (!div_trial[32]) begin
        step_acc = {div_trial[31:0], acc_q[30:0], 1'b1};
      end else begin
        step_acc = {acc_q[62:0], 1'b0};
      end
    end else begin
      step_acc = {mul_sum, acc_q[31:1]};
    end

    product = step_acc;
    fin_hi  = 32'd0;
    fin_lo  = 32'd0;
    if (!md_op_q[1]) begin
      if (!md_op_q[0] && (a_neg_q ^ b_neg_q)) begin
        product = 64'd0 - step_acc;
      end else begin
        product = step_acc;
      end
      fin_hi = product[63:32];
      fin_lo = product[31:0];
    end else if (opb_q == 32'd0) begin
      fin_hi = dividend_q;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_lo = (!md_op_q[0] && (a_neg_q ^ b_neg_q)) ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
      fin_hi = (!md_op_q[0] && a_neg_q) ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
    end
  end

  // Multiply/divide FSM next-state and HI/LO update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    dividend_d = dividend_q;
    md_op_d    = md_op_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md_issue) begin
          state_d    = MD_BUSY;
          cnt_d      = 5'd31;
          md_op_d    = funct[1:0];
          a_neg_d    = !funct[0] && op_a[31];
          b_neg_d    = !funct[0] && op_b[31];
          acc_d      = {32'd0, magnitude(op_a, !funct[0])};
          opb_d      = magnitude(op_b, !funct[0]);
          dividend_d = op_a;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        acc_d = step_acc;
        if (cnt_q == 5'd0) begin
          state_d = MD_DONE;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // Integer ALU
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b11: alu_result = op_a | op_b;
      2'b10: begin
        case (funct)
          6'h20, 6'h21: alu_result = op_a + op_b;
          6'h22, 6'h23: alu_result = op_a - op_b;
          6'h24:        alu_result = op_a & op_b;
          6'h25:        alu_result = op_a | op_b;
          6'h26:        alu_result = op_a ^ op_b;
          6'h27:        alu_result = ~(op_a | op_b);
          6'h2A:        alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
          6'h2B:        alu_result = {31'd0, (op_a < op_b)};
          6'h00:        alu_result = op_b << shamt;
          6'h02:        alu_result = op_b >> shamt;
          6'h03:        alu_result = $signed(op_b) >>> shamt;
          6'h10:        alu_result = hi_q;
          6'h12:        alu_result = lo_q;
          default:      alu_result = 32'd0;
        endcase
      end
      default: alu_result = 32'd0;
    endcase
  end

  // EX/MEM next value: a bubble whenever upstream is frozen
  always_comb begin
    ctrl_d   = 5'd0;
    result_d = 32'd0;
    read2_d  = 32'd0;
    dest_d   = 5'd0;
    if (stall) begin
      ctrl_d   = 5'd0;
      result_d = 32'd0;
      read2_d  = 32'd0;
      dest_d   = 5'd0;
    end else begin
      ctrl_d   = ctrlMEMWB;
      result_d = alu_result;
      read2_d  = read2;
      dest_d   = reg_dst ? rd : rt;
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      cnt_q      <= 5'd0;
      acc_q      <= 64'd0;
      opb_q      <= 32'd0;
      dividend_q <= 32'd0;
      md_op_q    <= 2'd0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      ctrl_q     <= 5'd0;
      result_q   <= 32'd0;
      read2_q    <= 32'd0;
      dest_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      dividend_q <= dividend_d;
      md_op_q    <= md_op_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ctrl_q     <= ctrl_d;
      result_q   <= result_d;
      read2_q    <= read2_d;
      dest_q     <= dest_d;
    end
  end

  assign controlBits = ctrl_q;
  assign resultULA   = result_q;
  assign read2Out    = read2_q;
  assign entradaMUX5 = dest_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage : self-checking bench for ex_stage. Directed cases plus
// randomized ALU and multiply/divide traffic checked against an arithmetic
// reference model of the execute stage.
// ---------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  ctrlEX;
  logic [4:0]  ctrlMEMWB;
  logic [31:0] read1;
  logic [31:0] read2;
  logic [31:0] immediate;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  controlBits;
  logic [31:0] resultULA;
  logic [31:0] read2Out;
  logic [4:0]  entradaMUX5;
  logic        stall;

  int tests_run;
  int tests_failed;

  // Reference HI/LO
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  logic [5:0] alu_functs [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3F};

  ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ctrlEX      (ctrlEX),
    .ctrlMEMWB   (ctrlMEMWB),
    .read1       (read1),
    .read2       (read2),
    .immediate   (immediate),
    .rt          (rt),
    .rd          (rd),
    .controlBits (controlBits),
    .resultULA   (resultULA),
    .read2Out    (read2Out),
    .entradaMUX5 (entradaMUX5),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_imm(input logic [4:0] sh, input logic [5:0] f);
    return {21'd0, sh, f};
  endfunction

  task automatic drive(input logic [3:0] cx, input logic [4:0] mw, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rtv, input logic [4:0] rdv);
    ctrlEX    = cx;
    ctrlMEMWB = mw;
    read1     = a;
    read2     = b;
    immediate = imm;
    rt        = rtv;
    rd        = rdv;
  endtask

  // Reference ALU: result of one instruction from the ISA rules
  function automatic logic [31:0] model_alu(input logic [3:0] cx, input logic [31:0] a,
                                            input logic [31:0] r2, input logic [31:0] imm);
    logic [31:0] b;
    logic [63:0] ext;
    int          sh;
    b   = cx[2] ? imm : r2;
    sh  = int'(imm[10:6]);
    ext = {{32{b[31]}}, b};
    if (cx[1:0] == 2'b00) return a + b;
    if (cx[1:0] == 2'b01) return a - b;
    if (cx[1:0] == 2'b11) return a | b;
    case (imm[5:0])
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'h2B: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: begin ext = ext >> sh; return ext[31:0]; end
      6'h10: return m_hi;
      6'h12: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Reference multiply/divide using native 64-bit arithmetic
  task automatic model_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, tq, tr;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    case (f)
      6'h18: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h19: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'h1A: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin
          q = sa / sb; r = sa % sb; tq = q; tr = r;
          m_lo = tq[31:0]; m_hi = tr[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
    endcase
  endtask

  // One ALU instruction: no stall, registered result one cycle later
  task automatic alu_check(input string tag, input logic [3:0] cx, input logic [31:0] a,
                           input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] exp_res);
    logic [4:0] mw, rtv, rdv;
    mw  = 5'($urandom);
    rtv = 5'($urandom);
    rdv = 5'($urandom);
    drive(cx, mw, a, r2, imm, rtv, rdv);
    #1;
    check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_result"}, resultULA, exp_res);
    check_eq({tag, "_ctrl"}, {27'd0, controlBits}, {27'd0, mw});
    check_eq({tag, "_read2"}, read2Out, r2);
    check_eq({tag, "_dest"}, {27'd0, entradaMUX5}, {27'd0, (cx[3] ? rdv : rtv)});
  endtask

  // One md instruction: 33 stall cycles of bubbles, then retire in DONE.
  // mid_read 1/2 replaces the held instruction with mfhi/mflo once BUSY.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int mid_read);
    logic [4:0] mw, rdv;
    int         n;
    mw  = 5'($urandom);
    rdv = 5'($urandom_range(1, 31));
    drive(4'b1010, mw, a, b, mk_imm(5'd0, f), 5'd3, rdv);
    model_md(f, a, b);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
      check_eq({tag, "_bubble"},
               resultULA | read2Out | {27'd0, controlBits} | {27'd0, entradaMUX5}, 32'd0);
      if (n == 1 && mid_read != 0)
        drive(4'b1010, mw, a, b, mk_imm(5'd0, (mid_read == 1) ? 6'h10 : 6'h12), 5'd3, rdv);
      #1;
    end
    check_eq({tag, "_stall_cycles"}, 32'(n), 32'd33);
    @(posedge clk); #1;
    check_eq({tag, "_retire_ctrl"}, {27'd0, controlBits}, {27'd0, mw});
    check_eq({tag, "_retire_dest"}, {27'd0, entradaMUX5}, {27'd0, rdv});
    check_eq({tag, "_retire_read2"}, read2Out, b);
    if (mid_read == 1) check_eq({tag, "_busy_mfhi"}, resultULA, m_hi);
    if (mid_read == 2) check_eq({tag, "_busy_mflo"}, resultULA, m_lo);
  endtask

  initial begin
    logic [3:0]  cx;
    logic [31:0] a, b, imm;
    logic [5:0]  f1, f2;
    tests_run    = 0;
    tests_failed = 0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Reset with live, non-zero inputs
    reset = 1'b1;
    drive(4'b1010, 5'h1F, 32'h1234_5678, 32'h0BAD_F00D, mk_imm(5'd0, 6'h20), 5'd4, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_stall", {31'd0, stall}, 32'd0);
    check_eq("reset_result", resultULA, 32'd0);
    check_eq("reset_ctrl", {27'd0, controlBits}, 32'd0);
    check_eq("reset_read2", read2Out, 32'd0);
    check_eq("reset_dest", {27'd0, entradaMUX5}, 32'd0);
    reset = 1'b0;

    // Directed ALU cases
    alu_check("add_wrap", 4'b1010, 32'h7FFF_FFFF, 32'd1, mk_imm(5'd0, 6'h20), 32'h8000_0000);
    alu_check("slt", 4'b1010, 32'hFFFF_FFFF, 32'd1, mk_imm(5'd0, 6'h2A), 32'd1);
    alu_check("sltu", 4'b1010, 32'hFFFF_FFFF, 32'd1, mk_imm(5'd0, 6'h2B), 32'd0);
    alu_check("sra", 4'b1010, 32'd0, 32'h8000_0000, mk_imm(5'd4, 6'h03), 32'hF800_0000);
    alu_check("load_addr", 4'b0100, 32'h0000_0100, 32'hCAFE_0001, 32'hFFFF_FFFC, 32'h0000_00FC);
    alu_check("bad_funct", 4'b1010, 32'h55, 32'h66, mk_imm(5'd0, 6'h3F), 32'd0);

    // Signed multiply and divides
    run_md("mult", 6'h18, 32'hFFFF_FFFD, 32'd5, 0);
    alu_check("mult_mfhi", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h10), 32'hFFFF_FFFF);
    alu_check("mult_mflo", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h12), 32'hFFFF_FFF1);
    run_md("div", 6'h1A, 32'd7, 32'hFFFF_FFFE, 0);
    alu_check("div_mflo", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h12), 32'hFFFF_FFFD);
    alu_check("div_mfhi", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h10), 32'd1);
    run_md("divu0", 6'h1B, 32'd9, 32'd0, 2);
    alu_check("divu0_mflo", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h12), 32'hFFFF_FFFF);
    alu_check("divu0_mfhi", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h10), 32'd9);

    // Randomized back-to-back md pairs
    for (int i = 0; i < 4; i++) begin
      f1 = 6'h18 + 6'($urandom_range(0, 3));
      f2 = 6'h18 + 6'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 1) ? 32'd0 : $urandom;
      run_md("md_rand_a", f1, a, b, 0);
      a  = $urandom;
      b  = (i == 2) ? 32'(int'($urandom_range(0, 15)) - 8) : $urandom;
      run_md("md_rand_b", f2, a, b, (i == 3) ? 1 : 0);
      alu_check("md_rand_mfhi", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h10), m_hi);
      alu_check("md_rand_mflo", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h12), m_lo);
    end

    // Randomized ALU traffic
    for (int i = 0; i < 60; i++) begin
      cx  = 4'($urandom);
      a   = $urandom;
      b   = $urandom;
      imm = $urandom;
      if (cx[1:0] == 2'b10) imm[5:0] = alu_functs[$urandom_range(0, 15)];
      alu_check("alu_rand", cx, a, b, imm, model_alu(cx, a, b, imm));
    end

    // Reset on the 10th BUSY cycle of a multiply
    drive(4'b1010, 5'h1F, 32'hFFFF_FFFD, 32'd5, mk_imm(5'd0, 6'h18), 5'd2, 5'd9);
    #1;
    check_eq("rst_busy_issue_stall", {31'd0, stall}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("rst_busy_pre_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    drive(4'b0000, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("rst_busy_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_busy_outputs",
             resultULA | read2Out | {27'd0, controlBits} | {27'd0, entradaMUX5}, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    alu_check("rst_mfhi", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h10), 32'd0);
    alu_check("rst_mflo", 4'b1010, 32'd0, 32'd0, mk_imm(5'd0, 6'h12), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
